// File: rtl/string_cmp_engine.sv
// strcmp-style compare of two packed-character word streams popped from FIFO A and FIFO B.
// Stops on first differing byte, shared NUL, or the programmed (clamped) character count.
module string_cmp_engine #(
    parameter int MAX_WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_go,
    input  logic [4:0]  i_length,
    input  logic [31:0] i_a_word,
    input  logic        i_a_valid,
    output logic        o_a_pop,
    input  logic [31:0] i_b_word,
    input  logic        i_b_valid,
    output logic        o_b_pop,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_match,
    output logic [8:0]  o_diff,
    output logic [4:0]  o_mis_index
);
    localparam logic [4:0] LIMIT = 5'(MAX_WORDS * 4);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CMP, S_DONE} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_a_word, w_a_word_next;
    logic [31:0] r_b_word, w_b_word_next;
    logic [4:0]  r_cnt, w_cnt_next;
    logic [4:0]  r_len, w_len_next;
    logic [1:0]  r_ptr, w_ptr_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic        r_match, w_match_next;
    logic [8:0]  r_diff, w_diff_next;
    logic [4:0]  r_mis_index, w_mis_index_next;
    logic        w_pop;
    logic [4:0]  w_len_clamped;
    logic [4:0]  w_cnt_inc;
    logic [7:0]  w_a_byte [4];
    logic [7:0]  w_b_byte [4];
    logic [7:0]  w_ca, w_cb;

    // Byte 0 is the most significant byte of each word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign w_a_byte[gi] = r_a_word[31-8*gi -: 8];
        assign w_b_byte[gi] = r_b_word[31-8*gi -: 8];
    end

    assign w_ca          = w_a_byte[r_ptr];
    assign w_cb          = w_b_byte[r_ptr];
    assign w_len_clamped = (i_length > LIMIT) ? LIMIT : i_length;
    assign w_cnt_inc     = r_cnt + 5'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_a_word    <= '0;
            r_b_word    <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_ptr       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_match     <= 1'b0;
            r_diff      <= '0;
            r_mis_index <= '0;
        end else begin
            r_state     <= w_state_next;
            r_a_word    <= w_a_word_next;
            r_b_word    <= w_b_word_next;
            r_cnt       <= w_cnt_next;
            r_len       <= w_len_next;
            r_ptr       <= w_ptr_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_match     <= w_match_next;
            r_diff      <= w_diff_next;
            r_mis_index <= w_mis_index_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_a_word_next    = r_a_word;
        w_b_word_next    = r_b_word;
        w_cnt_next       = r_cnt;
        w_len_next       = r_len;
        w_ptr_next       = r_ptr;
        w_busy_next      = r_busy;
        w_done_next      = r_done;
        w_match_next     = r_match;
        w_diff_next      = r_diff;
        w_mis_index_next = r_mis_index;
        w_pop            = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_go) begin
                    w_done_next      = 1'b0;
                    w_match_next     = 1'b0;
                    w_diff_next      = '0;
                    w_mis_index_next = '0;
                    w_cnt_next       = '0;
                    w_len_next       = w_len_clamped;
                    if (w_len_clamped == 5'd0) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                        w_match_next = 1'b1;
                        w_busy_next  = 1'b0;
                    end else begin
                        w_state_next = S_FETCH;
                        w_busy_next  = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (i_a_valid && i_b_valid) begin
                    w_pop         = 1'b1;
                    w_a_word_next = i_a_word;
                    w_b_word_next = i_b_word;
                    w_ptr_next    = 2'd0;
                    w_state_next  = S_CMP;
                end
            end
            S_CMP: begin
                if (w_ca != w_cb) begin
                    w_match_next     = 1'b0;
                    w_diff_next      = {1'b0, w_ca} - {1'b0, w_cb};
                    w_mis_index_next = r_cnt;
                    w_state_next     = S_DONE;
                    w_done_next      = 1'b1;
                    w_busy_next      = 1'b0;
                end else if (w_ca == 8'h00) begin
                    w_match_next     = 1'b1;
                    w_mis_index_next = r_cnt;
                    w_state_next     = S_DONE;
                    w_done_next      = 1'b1;
                    w_busy_next      = 1'b0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_match_next     = 1'b1;
                        w_mis_index_next = r_len;
                        w_state_next     = S_DONE;
                        w_done_next      = 1'b1;
                        w_busy_next      = 1'b0;
                    end else if (r_ptr == 2'd3) begin
                        w_state_next = S_FETCH;
                    end else begin
                        w_ptr_next = r_ptr + 2'd1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pops are the only outputs allowed to follow the FIFO valids combinationally.
    assign o_a_pop     = w_pop;
    assign o_b_pop     = w_pop;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_match     = r_match;
    assign o_diff      = r_diff;
    assign o_mis_index = r_mis_index;
endmodule

// File: tb/tb_string_cmp_engine.sv
// Directed-vector bench for string_cmp_engine with a 4-deep behavioural FIFO model per side.
module tb_string_cmp_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_go;
    logic [4:0]  i_length;
    logic [31:0] i_a_word, i_b_word;
    logic        i_a_valid, i_b_valid;
    logic        o_a_pop, o_b_pop, o_busy, o_done, o_match;
    logic [8:0]  o_diff;
    logic [4:0]  o_mis_index;

    int errors = 0;
    int checks = 0;

    logic [31:0] a_mem [4];
    logic [31:0] b_mem [4];
    int          a_idx, b_idx, pop_cnt;
    logic        pair_err, prev_pop, fifo_clear, b_hold;

    typedef struct {
        string        name;
        logic [4:0]   len;
        logic [127:0] a;
        logic [127:0] b;
        logic         exp_match;
        logic [8:0]   exp_diff;
        logic [4:0]   exp_mis;
        int           exp_pops;
        int           exp_lat;
        int           stall;
        int           mid_go;
    } vec_t;

    vec_t vecs [13];

    string_cmp_engine #(.MAX_WORDS(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_go(i_go), .i_length(i_length),
        .i_a_word(i_a_word), .i_a_valid(i_a_valid), .o_a_pop(o_a_pop),
        .i_b_word(i_b_word), .i_b_valid(i_b_valid), .o_b_pop(o_b_pop),
        .o_busy(o_busy), .o_done(o_done), .o_match(o_match),
        .o_diff(o_diff), .o_mis_index(o_mis_index)
    );

    always #5 clk = ~clk;

    assign i_a_valid = (a_idx < 4);
    assign i_b_valid = (b_idx < 4) && !b_hold;
    assign i_a_word  = (a_idx < 4) ? a_mem[a_idx[1:0]] : 32'h0;
    assign i_b_word  = (b_idx < 4) ? b_mem[b_idx[1:0]] : 32'h0;

    always @(posedge clk) begin
        if (fifo_clear) begin
            a_idx <= 0; b_idx <= 0; pop_cnt <= 0;
            pair_err <= 1'b0; prev_pop <= 1'b0;
        end else begin
            if (o_a_pop) a_idx <= a_idx + 1;
            if (o_b_pop) b_idx <= b_idx + 1;
            if (o_a_pop && o_b_pop) pop_cnt <= pop_cnt + 1;
            if (o_a_pop != o_b_pop) pair_err <= 1'b1;
            if (o_a_pop && prev_pop) pair_err <= 1'b1;
            if (o_a_pop && !(i_a_valid && i_b_valid)) pair_err <= 1'b1;
            prev_pop <= o_a_pop;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            a_mem[i] = v.a[127-32*i -: 32];
            b_mem[i] = v.b[127-32*i -: 32];
        end
        fifo_clear = 1'b1;
        @(posedge clk); #1;
        fifo_clear = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        load(v);
        b_hold   = (v.stall > 0);
        i_length = v.len;
        i_go     = 1'b1;
        @(posedge clk); #1;
        i_go = 1'b0;
        cyc  = 1;
        chk({v.name, ".busy_t1"}, int'(o_busy), (v.len != 0) ? 1 : 0);
        chk({v.name, ".done_t1"}, int'(o_done), (v.len == 0) ? 1 : 0);
        while (!o_done && cyc < 100) begin
            i_go = (cyc == v.mid_go);
            if (v.stall > 0 && cyc == v.stall + 1) begin
                chk({v.name, ".stall_nopop"}, pop_cnt, 0);
                b_hold = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_go   = 1'b0;
        b_hold = 1'b0;
        chk({v.name, ".done"},  int'(o_done), 1);
        chk({v.name, ".match"}, int'(o_match), int'(v.exp_match));
        chk({v.name, ".diff"},  int'(o_diff), int'(v.exp_diff));
        chk({v.name, ".mis"},   int'(o_mis_index), int'(v.exp_mis));
        chk({v.name, ".pops"},  pop_cnt, v.exp_pops);
        chk({v.name, ".lat"},   cyc, v.exp_lat);
        chk({v.name, ".busy_end"}, int'(o_busy), 0);
        chk({v.name, ".pop_rules"}, int'(pair_err), 0);
        $display("txn %-10s len=%0d match=%0d diff=%03h mis=%0d pops=%0d lat=%0d",
                 v.name, v.len, o_match, o_diff, o_mis_index, pop_cnt, cyc);
    endtask

    function automatic vec_t mk(input string nm, input logic [4:0] len,
                                input logic [127:0] a, input logic [127:0] b,
                                input logic m, input logic [8:0] d, input logic [4:0] mi,
                                input int pops, input int lat, input int stall, input int mid);
        vec_t v;
        v.name = nm; v.len = len; v.a = a; v.b = b;
        v.exp_match = m; v.exp_diff = d; v.exp_mis = mi;
        v.exp_pops = pops; v.exp_lat = lat; v.stall = stall; v.mid_go = mid;
        return v;
    endfunction

    localparam logic [127:0] S_ABCDEFG0 = 128'h41424344_45464700_00000000_00000000;
    localparam logic [127:0] S_ALPHA16  = 128'h41424344_45464748_494A4B4C_4D4E4F50;
    localparam logic [127:0] S_ALPHA16Z = 128'h41424344_45464748_494A4B4C_4D4E4F5A;

    initial begin
        vec_t vr;
        vecs[0]  = mk("eq_nul",    5'd16, S_ABCDEFG0, S_ABCDEFG0, 1'b1, 9'h000, 5'd7,  2, 11, 0, 0);
        vecs[1]  = mk("abxd",      5'd4,  {32'h41424344, 96'h0}, {32'h41425844, 96'h0},
                      1'b0, 9'h1EB, 5'd2, 1, 5, 0, 0);
        vecs[2]  = mk("len0",      5'd0,  S_ALPHA16, S_ALPHA16, 1'b1, 9'h000, 5'd0, 0, 1, 0, 0);
        vecs[3]  = mk("len5",      5'd5,  S_ALPHA16, S_ALPHA16, 1'b1, 9'h000, 5'd5, 2, 8, 0, 0);
        vecs[4]  = mk("full16",    5'd16, S_ALPHA16, S_ALPHA16, 1'b1, 9'h000, 5'd16, 4, 21, 0, 0);
        vecs[5]  = mk("len31_go",  5'd31, S_ALPHA16, S_ALPHA16, 1'b1, 9'h000, 5'd16, 4, 21, 0, 5);
        vecs[6]  = mk("pos_diff",  5'd16, {32'h5A000000, 96'h0}, {32'h41000000, 96'h0},
                      1'b0, 9'h019, 5'd0, 1, 3, 0, 0);
        vecs[7]  = mk("b_short",   5'd16, {32'h41424300, 96'h0}, {32'h41420000, 96'h0},
                      1'b0, 9'h043, 5'd2, 1, 5, 0, 0);
        vecs[8]  = mk("nul_first", 5'd16, 128'h0, 128'h0, 1'b1, 9'h000, 5'd0, 1, 3, 0, 0);
        vecs[9]  = mk("last_mis",  5'd16, S_ALPHA16, S_ALPHA16Z, 1'b0, 9'h1F6, 5'd15, 4, 21, 0, 0);
        vecs[10] = mk("len1",      5'd1,  S_ALPHA16, S_ALPHA16Z, 1'b1, 9'h000, 5'd1, 1, 3, 0, 0);
        vecs[11] = mk("ff_vs_00",  5'd16, {32'h00000000, 96'h0}, {32'hFF000000, 96'h0},
                      1'b0, 9'h101, 5'd0, 1, 3, 0, 0);
        vecs[12] = mk("stall_b",   5'd16, S_ABCDEFG0, S_ABCDEFG0, 1'b1, 9'h000, 5'd7, 2, 17, 6, 0);

        rst_n = 1'b0; i_go = 1'b0; i_length = 5'd0; b_hold = 1'b0; fifo_clear = 1'b1;
        for (int i = 0; i < 4; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy",  int'(o_busy), 0);
        chk("rst.done",  int'(o_done), 0);
        chk("rst.match", int'(o_match), 0);
        chk("rst.diff",  int'(o_diff), 0);
        chk("rst.mis",   int'(o_mis_index), 0);
        chk("rst.pop",   int'(o_a_pop | o_b_pop), 0);
        rst_n = 1'b1;
        fifo_clear = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of word 2 of a 16-char compare.
        vr = vecs[4];
        load(vr);
        i_length = vr.len;
        i_go = 1'b1;
        @(posedge clk); #1;
        i_go = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        chk("midrst.busy_before", int'(o_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy",  int'(o_busy), 0);
        chk("midrst.done",  int'(o_done), 0);
        chk("midrst.match", int'(o_match), 0);
        chk("midrst.diff",  int'(o_diff), 0);
        chk("midrst.mis",   int'(o_mis_index), 0);
        chk("midrst.pop",   int'(o_a_pop | o_b_pop), 0);
        chk("midrst.pops_so_far", pop_cnt, 2);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst.no_pop_held", pop_cnt, 2);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst.idle_busy", int'(o_busy), 0);
        vr = vecs[1];
        vr.name = "after_rst";
        run_vec(vr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
